// File: rtl/mic1_pkg.sv
// Shared types and constants for the Mic-1 instruction fetch unit.
package mic1_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IFU_DEPTH      = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } ifu_state_e;

endpackage

// File: rtl/mic1_byte_queue.sv
// Byte shift queue: pops 0..2 head bytes and appends 0..4 bytes of a big-endian
// word (starting at byte `skip`) in the same cycle; remaining bytes stay in front.
module mic1_byte_queue
  import mic1_pkg::*;
#(
  parameter int DEPTH = IFU_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [2:0]                 push_n,
  input  logic [31:0]                word,
  input  logic [1:0]                 skip,
  input  logic [1:0]                 pop_n,
  output logic [7:0]                 head0,
  output logic [7:0]                 head1,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    q      [DEPTH];
  logic [7:0]    q_next [DEPTH];
  logic [CW-1:0] count_next;

  // NOTE: every comb output gets a default first, so no latch can be inferred.
  always_comb begin
    int remaining;
    q_next     = q;
    remaining  = int'(count) - int'(pop_n);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < remaining)
        q_next[i] = q[i + int'(pop_n)];
      else if (i - remaining < int'(push_n))
        q_next[i] = word[31 - 8 * (int'(skip) + i - remaining) -: 8];
      else
        q_next[i] = 8'h00;
    end
    count_next = flush ? '0 : CW'(remaining + int'(push_n));
  end

  // NOTE: the byte storage is small enough to reset, which keeps head bytes
  // deterministic; the outputs are gated by count anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= '{default: 8'h00};
      count <= '0;
    end else begin
      q     <= q_next;
      count <= count_next;
    end
  end

  assign head0 = q[0];
  assign head1 = q[1];

endmodule

// File: rtl/mic1_ifu.sv
// Mic-1 instruction fetch unit: one-outstanding-request word fetcher feeding a
// byte queue that presents MBR/MBR2 to the datapath, with PC redirect.
module mic1_ifu
  import mic1_pkg::*;
#(
  parameter int DEPTH = IFU_DEPTH,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_in,
  input  logic          consume1,
  input  logic          consume2,
  output logic          imem_req,
  output logic [AW-3:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [7:0]    mbr,
  output logic [15:0]   mbr2,
  output logic          valid1,
  output logic          valid2,
  output logic [AW-1:0] pc_out
);

  localparam int CW = $clog2(DEPTH + 1);

  ifu_state_e    state;
  logic [AW-3:0] fetch_ptr;
  logic [1:0]    skip;
  logic [CW-1:0] count;
  logic [2:0]    push_n;
  logic [1:0]    pop_n;
  logic [7:0]    head0, head1;
  logic          room;

  // A word is requested only if it is guaranteed to fit when it lands.
  assign room = count <= CW'(DEPTH - BYTES_PER_WORD);

  always_comb begin
    pop_n  = 2'd0;
    push_n = 3'd0;
    if (!pc_load) begin
      if (consume2 && count >= CW'(2))
        pop_n = 2'd2;
      else if (consume1 && count != '0)
        pop_n = 2'd1;
      if (state == WAIT && imem_ack)
        push_n = 3'(BYTES_PER_WORD) - 3'(skip);
    end
  end

  mic1_byte_queue #(.DEPTH(DEPTH)) u_queue (
    .clk    (clk),
    .rst    (rst),
    .flush  (pc_load),
    .push_n (push_n),
    .word   (imem_rdata),
    .skip   (skip),
    .pop_n  (pop_n),
    .head0  (head0),
    .head1  (head1),
    .count  (count)
  );

  // NOTE: sequential state uses non-blocking assignments only, so the later
  // redirect assignments below cleanly override the FSM's pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fetch_ptr <= '0;
      skip      <= 2'd0;
      pc_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            imem_req  <= 1'b1;
            imem_addr <= pc_in[AW-1:2];
            state     <= WAIT;
          end else if (room) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_ptr;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            imem_req  <= 1'b0;
            fetch_ptr <= fetch_ptr + 1'b1;
            state     <= IDLE;
          end else if (pc_load) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase

      if (pc_load) begin
        pc_out    <= pc_in;
        fetch_ptr <= pc_in[AW-1:2];
        skip      <= pc_in[1:0];
      end else begin
        pc_out <= pc_out + AW'(pop_n);
        if (push_n != 3'd0)
          skip <= 2'd0;
      end
    end
  end

  assign valid1 = count != '0;
  assign valid2 = count >= CW'(2);
  assign mbr    = valid1 ? head0 : 8'h00;
  assign mbr2   = valid2 ? {head0, head1} : 16'h0000;

endmodule
